// File: rtl/vga_sync_to_count.sv
// Recovers column/row counts from a generator-style HSync/VSync pair, re-times the syncs,
// and tracks frame lock plus frame/line period errors.
module vga_sync_to_count #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_HSync,
  input  logic       i_VSync,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Active,
  output logic       o_Frame_Start,
  output logic       o_Locked,
  output logic       o_Frame_Err,
  output logic       o_Line_Err,
  output logic [7:0] o_Err_Count
);

  localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
  localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);
  localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);

  logic       hs_q, vs_q;
  logic [9:0] col_q, col_d, row_q, row_d;
  logic       active_q, active_d;
  logic       frame_start_q, frame_start_d;
  logic       locked_q, locked_d;
  logic       frame_err_q, frame_err_d;
  logic       line_err_q, line_err_d;
  logic [7:0] err_q, err_d;
  logic [3:0] good_q, good_d;
  logic       seen_q, seen_d;

  logic vs_rise, hs_rise, at_col_last, at_end, frame_good;

  always_comb begin
    vs_rise     = i_VSync & ~vs_q;
    hs_rise     = i_HSync & ~hs_q;
    at_col_last = (col_q == COL_LAST);
    at_end      = at_col_last && (row_q == ROW_LAST);

    col_d = col_q + 10'd1;
    row_d = row_q;
    if (vs_rise) begin
      col_d = '0;
      row_d = '0;
    end else if (at_col_last) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 10'd1;
    end

    // A frame is judged only once a first VSync rise has established alignment;
    // reaching the frame end without a VSync rise counts as a missed frame.
    frame_good  = seen_q & vs_rise & at_end;
    frame_err_d = seen_q & (vs_rise ^ at_end);
    line_err_d  = seen_q & hs_rise & ~at_col_last & ~vs_rise;
    seen_d      = seen_q | vs_rise;

    good_d   = good_q;
    locked_d = locked_q;
    if (frame_err_d || line_err_d) begin
      good_d   = '0;
      locked_d = 1'b0;
    end else if (frame_good) begin
      if (good_q != LOCK_N) good_d = good_q + 4'd1;
      if (good_d == LOCK_N) locked_d = 1'b1;
    end

    err_d = err_q;
    if ((frame_err_d || line_err_d) && (err_q != '1)) err_d = err_q + 8'd1;

    active_d      = (col_d < ACT_COLS) && (row_d < ACT_ROWS);
    frame_start_d = vs_rise;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      frame_err_q   <= 1'b0;
      line_err_q    <= 1'b0;
      err_q         <= '0;
      good_q        <= '0;
      seen_q        <= 1'b0;
    end else begin
      hs_q          <= i_HSync;
      vs_q          <= i_VSync;
      col_q         <= col_d;
      row_q         <= row_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      frame_err_q   <= frame_err_d;
      line_err_q    <= line_err_d;
      err_q         <= err_d;
      good_q        <= good_d;
      seen_q        <= seen_d;
    end
  end

  assign o_HSync       = hs_q;
  assign o_VSync       = vs_q;
  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_Active      = active_q;
  assign o_Frame_Start = frame_start_q;
  assign o_Locked      = locked_q;
  assign o_Frame_Err   = frame_err_q;
  assign o_Line_Err    = line_err_q;
  assign o_Err_Count   = err_q;

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Directed bench for vga_sync_to_count on a 10x6 frame (8x4 active), LOCK_FRAMES=2.
module tb_vga_sync_to_count;

  logic       clk, rst, hs_in, vs_in;
  logic       o_HSync, o_VSync, o_Active, o_Frame_Start, o_Locked, o_Frame_Err, o_Line_Err;
  logic [9:0] o_Col_Count, o_Row_Count;
  logic [7:0] o_Err_Count;

  int compared = 0;
  int mismatched = 0;
  int gc = 0, gr = 0;
  bit pos_chk = 0, vs_mask = 0, hs_kill = 0;
  int fe_cnt = 0, le_cnt = 0, act_cnt = 0, fs_cnt = 0;

  vga_sync_to_count #(
    .TOTAL_COLS(10), .TOTAL_ROWS(6), .ACTIVE_COLS(8), .ACTIVE_ROWS(4), .LOCK_FRAMES(2)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_HSync(hs_in), .i_VSync(vs_in),
    .o_HSync(o_HSync), .o_VSync(o_VSync), .o_Col_Count(o_Col_Count), .o_Row_Count(o_Row_Count),
    .o_Active(o_Active), .o_Frame_Start(o_Frame_Start), .o_Locked(o_Locked),
    .o_Frame_Err(o_Frame_Err), .o_Line_Err(o_Line_Err), .o_Err_Count(o_Err_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic hs, input logic vs);
    @(negedge clk);
    hs_in = hs;
    vs_in = vs;
    @(posedge clk);
    #1;
  endtask

  // One pixel of the ideal generator at (gc,gr), then advance the generator.
  task automatic gen_step();
    drive((gc < 8) && !hs_kill, (gr < 4) && !vs_mask);
    if (pos_chk) begin
      chk("col", 32'(o_Col_Count), gc);
      chk("row", 32'(o_Row_Count), gr);
    end
    fe_cnt += int'(o_Frame_Err);
    le_cnt += int'(o_Line_Err);
    act_cnt += int'(o_Active);
    fs_cnt += int'(o_Frame_Start);
    if (gc == 9) begin
      gc = 0;
      gr = (gr == 5) ? 0 : gr + 1;
    end else begin
      gc = gc + 1;
    end
  endtask

  task automatic run_gen(input int n);
    for (int i = 0; i < n; i++) gen_step();
  endtask

  initial begin
    rst = 1'b1;
    hs_in = 1'b0;
    vs_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", 32'(o_Col_Count), 0);
    chk("rst_row", 32'(o_Row_Count), 0);
    chk("rst_locked", 32'(o_Locked), 0);
    chk("rst_errcnt", 32'(o_Err_Count), 0);
    chk("rst_fs", 32'(o_Frame_Start), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) drive(1'b0, 1'b0);
    chk("idle_ferr", 32'(o_Frame_Err), 0);

    // 1: ideal stream, 4 frames
    gc = 0; gr = 0; pos_chk = 1;
    fe_cnt = 0; le_cnt = 0; act_cnt = 0; fs_cnt = 0;
    gen_step();
    chk("t1_fs_first", 32'(o_Frame_Start), 1);
    chk("t1_vs_out", 32'(o_VSync), 1);
    chk("t1_hs_out", 32'(o_HSync), 1);
    chk("t1_ferr_first", 32'(o_Frame_Err), 0);
    run_gen(59);
    gen_step();
    chk("t1_lock_vs2", 32'(o_Locked), 0);
    run_gen(59);
    chk("t1_lock_pre_vs3", 32'(o_Locked), 0);
    gen_step();
    chk("t1_lock_vs3", 32'(o_Locked), 1);
    run_gen(59);
    gen_step();
    run_gen(59);
    chk("t1_active_cnt", act_cnt, 128);
    chk("t1_fs_cnt", fs_cnt, 4);
    chk("t1_ferr_cnt", fe_cnt, 0);
    chk("t1_lerr_cnt", le_cnt, 0);
    chk("t1_errcnt", 32'(o_Err_Count), 0);

    // 2: one frame of 59 clocks
    fe_cnt = 0;
    run_gen(59);
    chk("t2_lock_before", 32'(o_Locked), 1);
    gc = 0; gr = 0;
    gen_step();
    chk("t2_ferr_pulse", 32'(o_Frame_Err), 1);
    chk("t2_lock_drop", 32'(o_Locked), 0);
    chk("t2_errcnt", 32'(o_Err_Count), 1);
    run_gen(59);
    gen_step();
    chk("t2_lock_one_good", 32'(o_Locked), 0);
    chk("t2_ferr_clear", 32'(o_Frame_Err), 0);
    run_gen(59);
    gen_step();
    chk("t2_relock", 32'(o_Locked), 1);
    run_gen(59);
    chk("t2_ferr_cnt", fe_cnt, 1);

    // 3: VSync held low for 2 frames
    fe_cnt = 0;
    vs_mask = 1;
    gen_step();
    chk("t3_ferr_first_wrap", 32'(o_Frame_Err), 1);
    run_gen(119);
    chk("t3_ferr_cnt", fe_cnt, 2);
    chk("t3_lock", 32'(o_Locked), 0);
    chk("t3_errcnt", 32'(o_Err_Count), 3);
    vs_mask = 0;
    gen_step();
    chk("t3_ferr_resume", 32'(o_Frame_Err), 0);
    chk("t3_lock_one_good", 32'(o_Locked), 0);
    run_gen(59);
    gen_step();
    chk("t3_relock", 32'(o_Locked), 1);
    run_gen(59);

    // 4: extra HSync rise at column 4
    le_cnt = 0;
    run_gen(13);
    hs_kill = 1;
    gen_step();
    hs_kill = 0;
    chk("t4_no_err_on_fall", 32'(o_Line_Err), 0);
    gen_step();
    chk("t4_lerr_pulse", 32'(o_Line_Err), 1);
    chk("t4_col", 32'(o_Col_Count), 4);
    chk("t4_row", 32'(o_Row_Count), 1);
    chk("t4_lock_drop", 32'(o_Locked), 0);
    chk("t4_errcnt", 32'(o_Err_Count), 4);
    gen_step();
    chk("t4_lerr_clear", 32'(o_Line_Err), 0);
    for (int i = 0; i < 100 && !(gc == 0 && gr == 0); i++) gen_step();
    chk("t4_lerr_cnt", le_cnt, 1);

    // 5: async reset at (5,2)
    for (int i = 0; i < 100 && !(gc == 5 && gr == 2); i++) gen_step();
    gen_step();
    chk("t5_pre_col", 32'(o_Col_Count), 5);
    chk("t5_pre_row", 32'(o_Row_Count), 2);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_async_col", 32'(o_Col_Count), 0);
    chk("t5_async_row", 32'(o_Row_Count), 0);
    chk("t5_async_vs", 32'(o_VSync), 0);
    chk("t5_async_hs", 32'(o_HSync), 0);
    chk("t5_async_active", 32'(o_Active), 0);
    chk("t5_async_errcnt", 32'(o_Err_Count), 0);
    chk("t5_async_lock", 32'(o_Locked), 0);
    pos_chk = 0;
    vs_mask = 1;
    run_gen(3);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100 && !(gc == 0 && gr == 0); i++) gen_step();
    chk("t5_no_lerr_unseen", le_cnt, 1);
    vs_mask = 0;
    pos_chk = 1;
    fe_cnt = 0;
    gen_step();
    chk("t5_first_fs", 32'(o_Frame_Start), 1);
    chk("t5_first_ferr", 32'(o_Frame_Err), 0);
    chk("t5_errcnt", 32'(o_Err_Count), 0);
    run_gen(59);
    gen_step();
    chk("t5_lock_one_good", 32'(o_Locked), 0);
    run_gen(59);
    gen_step();
    chk("t5_relock", 32'(o_Locked), 1);
    chk("t5_ferr_cnt", fe_cnt, 0);
    run_gen(59);

    // 6: toggle HSync every clock to pile up well over 255 errors
    pos_chk = 0;
    for (int i = 0; i < 800; i++) drive(1'(i % 2), 1'b0);
    chk("t6_errcnt_sat", 32'(o_Err_Count), 255);
    repeat (40) drive(1'b1, 1'b0);
    chk("t6_errcnt_hold", 32'(o_Err_Count), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
